imem_loader: RTL and testbench

//  Boot-time writer for the instruction memory the core fetches from (32-bit words, 16-bit word address).

---
 rtl/imem_loader_pkg.sv | 33 +++
 rtl/loader_timeout.sv | 38 +++
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// State encoding, error codes and the default frame start marker.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        CNT_LO = 3'd2,
        CNT_HI = 3'd3,
        DATA   = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_COUNT   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic is_busy(input state_t s);
        return (s == SYNC) || (s == CNT_LO) || (s == CNT_HI) ||
               (s == DATA) || (s == CSUM);
    endfunction

    // Stages where a stalled byte stream counts as a failed load.
    function automatic logic is_timed(input state_t s);
        return (s == CNT_LO) || (s == CNT_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inactivity watchdog for the boot loader.
// Ports: clk, reset, clear (restart count), enable (count), expired (limit hit).
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Fires on the TIMEOUT_CYCLES-th idle cycle after the last clear.
    assign expired = enable && !clear && (cnt_q >= LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: frames a byte stream, packs words, checks sum.
// Ports: rx_* byte stream in, mem_* write port out, cpu_hold/busy/done/error status.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH-1:0] words_written
);
    state_t                state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [23:0]           word_q, word_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [7:0]            sum_q, sum_d;
    // One extra bit so a full 2**ADDR_WIDTH load can be counted.
    logic [ADDR_WIDTH:0]   ww_q, ww_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [1:0]            err_code_q, err_code_d;

    logic        accept;
    logic        tmo_expired;
    logic [15:0] n_full;

    assign rx_ready      = is_busy(state_q);
    assign busy          = is_busy(state_q);
    assign accept        = rx_valid && rx_ready;
    assign n_full        = {rx_data, n_q[7:0]};
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign words_written = ww_q[ADDR_WIDTH-1:0];

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept || start || !is_timed(state_q)),
        .enable (is_timed(state_q)),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        word_d      = word_q;
        bcnt_d      = bcnt_q;
        sum_d       = sum_q;
        ww_d        = ww_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;

        if (start) begin
            // Re-arm; a byte offered in this cycle is dropped.
            state_d    = SYNC;
            cpu_hold_d = 1'b1;
            done_d     = 1'b0;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
            ww_d       = '0;
            sum_d      = '0;
            bcnt_d     = '0;
        end else if (tmo_expired) begin
            state_d    = ERR;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else if (accept) begin
            case (state_q)
                SYNC: begin
                    if (rx_data == SYNC_BYTE) state_d = CNT_LO;
                end
                CNT_LO: begin
                    n_d     = {n_q[15:8], rx_data};
                    sum_d   = sum_q + rx_data;
                    state_d = CNT_HI;
                end
                CNT_HI: begin
                    n_d   = n_full;
                    sum_d = sum_q + rx_data;
                    if ((n_full == 16'd0) ||
                        (32'(n_full) > (32'd1 << ADDR_WIDTH))) begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_COUNT;
                    end else begin
                        state_d = DATA;
                        bcnt_d  = '0;
                    end
                end
                DATA: begin
                    sum_d  = sum_q + rx_data;
                    word_d = {word_q[15:0], rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ww_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = {word_q, rx_data};
                        ww_d        = ww_q + 1'b1;
                        if (32'(ww_q) + 32'd1 == 32'(n_q)) state_d = CSUM;
                    end
                end
                CSUM: begin
                    if (rx_data == sum_q) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            word_q      <= '0;
            bcnt_q      <= '0;
            sum_q       <= '0;
            ww_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_q      <= word_d;
            bcnt_q      <= bcnt_d;
            sum_q       <= sum_d;
            ww_q        <= ww_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader.
// Expected writes are queued per frame; a monitor pops them on each mem_we.
module tb_imem_loader;
    localparam int AW  = 4;
    localparam int TMO = 100;
    localparam int MAXN = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold, busy, done, error;
    logic [1:0]    err_code;
    logic [AW-1:0] words_written;

    imem_loader #(
        .ADDR_WIDTH(AW),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .words_written(words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] words_q[$];
    logic [7:0]  pre_q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                chk("wr_data", mem_wdata, mon_e.data);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int  n = 0;
        bit  acc = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            n++;
        end
        rx_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_accept: byte %h not taken", b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic status(input string tag, input bit d, input bit e,
                          input logic [1:0] ec, input bit h, input bit b);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_error"}, 32'(error), 32'(e));
        chk({tag, "_err_code"}, 32'(err_code), 32'(ec));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    // Reference: builds the frame from words_q/pre_q, predicts writes and outcome.
    task automatic run_frame(input string tag, input int n, input bit bad_csum);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        bit         cnt_bad;
        cnt_bad = (n == 0) || (n > MAXN);
        sum = 8'(n % 256) + 8'(n / 256);
        foreach (pre_q[i]) bytes.push_back(pre_q[i]);
        bytes.push_back(8'hA5);
        bytes.push_back(8'(n % 256));
        bytes.push_back(8'(n / 256));
        if (!cnt_bad) begin
            for (int i = 0; i < n; i++) begin
                wr_t w;
                w.addr = AW'(i);
                w.data = words_q[i];
                exp_q.push_back(w);
                for (int k = 3; k >= 0; k--) begin
                    logic [7:0] by;
                    by = 8'((words_q[i] >> (8 * k)) & 32'hFF);
                    bytes.push_back(by);
                    sum = sum + by;
                end
            end
            bytes.push_back(bad_csum ? sum + 8'd1 : sum);
        end
        pulse_start();
        foreach (bytes[i]) begin
            send(bytes[i]);
            idle($urandom_range(0, 3));
        end
        idle(3);
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        if (cnt_bad)
            status(tag, 0, 1, 2'd1, 1, 0);
        else if (bad_csum)
            status(tag, 0, 1, 2'd3, 1, 0);
        else
            status(tag, 1, 0, 2'd0, 0, 0);
        if (!cnt_bad && n < MAXN)
            chk({tag, "_words_written"}, 32'(words_written), 32'(n));
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_words_written"}, 32'(words_written), 0);
        status(tag, 0, 0, 2'd0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        reset = 1'b0;
        all_zero("reset");

        for (int i = 0; i < 20; i++) begin
            rx_valid = 1'b1;
            rx_data  = (i % 3 == 0) ? 8'hA5 : 8'($urandom);
            @(negedge clk);
            chk("idle_rx_ready", 32'(rx_ready), 0);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        chk("idle_busy", 32'(busy), 0);

        words_q.delete();
        words_q.push_back(32'hD2800021);
        words_q.push_back(32'hD2800042);
        pre_q.delete();
        run_frame("t1", 2, 0);

        pre_q.push_back(8'h00);
        pre_q.push_back(8'hFF);
        pre_q.push_back(8'h13);
        run_frame("t2", 2, 0);
        pre_q.delete();

        run_frame("t3", 2, 1);
        chk("t3_words_written", 32'(words_written), 32'd2);

        run_frame("t4_n0", 0, 0);
        chk("t4_n0_ww", 32'(words_written), 0);
        run_frame("t4_n17", 17, 0);

        pulse_start();
        send(8'hA5); send(8'h01); send(8'h00); send(8'hD2);
        idle(95);
        chk("t5_early_error", 32'(error), 0);
        chk("t5_early_busy", 32'(busy), 1);
        idle(10);
        status("t5", 0, 1, 2'd2, 1, 0);

        pulse_start();
        send(8'hA5); send(8'h02); send(8'h00); send(8'hD2); send(8'h80);
        pulse_start();
        chk("t6_rearm_busy", 32'(busy), 1);
        chk("t6_rearm_ww", 32'(words_written), 0);
        words_q.delete();
        words_q.push_back(32'h12345678);
        run_frame("t6", 1, 0);

        pulse_start();
        send(8'hA5); send(8'h02); send(8'h00); send(8'hD2); send(8'h80);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        all_zero("t6_reset");

        for (int f = 0; f < 8; f++) begin
            int n;
            n = (f == 0) ? MAXN : int'($urandom_range(1, MAXN - 1));
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
            run_frame("rnd", n, ($urandom_range(0, 3) == 0));
        end

        words_q.delete();
        words_q.push_back($urandom);
        run_frame("pre_done", 1, 0);
        for (int i = 0; i < 10; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            @(negedge clk);
            chk("done_rx_ready", 32'(rx_ready), 0);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        status("done_hold", 1, 0, 2'd0, 0, 0);

        chk("final_queue", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
